pipe_stage_ctrl: RTL and testbench
==================================

// Module: pipe_stage_ctrl
// PURPOSE
//  Central handshake controller for the 5-stage in-order pipe (IF→ID→EX→MEM→WB).
//  - Owns the per-stage valid bits and derives the allowin chain.
//  - Drives the load enables that gate every inter-stage data register.
//  - Sequences the exception/ertn flush with a fixed front-end refill gap.
//  - Data registers (ID_EX, EX_MEM, MEM_WB) latch only on the matching *_load_o.
// PARAMETERS
//  FLUSH_GAP  2  cycles IF is blocked after a flush (0..15); 0 = no gap
// PORTS
//  clk            in   1  pipeline clock
//  rst_n          in   1  asynchronous reset, active low
//  if_valid_i     in   1  IF holds a fetched instruction
//  if_ready_go_i  in   1  IF instruction is complete and may leave IF
//  id_ready_go_i  in   1  ID work done (0 = interlock stall)
//  ex_ready_go_i  in   1  EX work done (0 = multi-cycle op busy)
//  mem_ready_go_i in   1  MEM work done (0 = waiting on data bus)
//  wb_ready_go_i  in   1  WB may retire
//  excep_flush_i  in   1  exception/ertn commit pulse from WB
//  if_allowin_o   out  1  IF may accept a new fetch
//  id_load_o      out  1  IF→ID register enable
//  ex_load_o      out  1  ID→EX register enable
//  mem_load_o     out  1  EX→MEM register enable
//  wb_load_o      out  1  MEM→WB register enable
//  id_valid_o     out  1  ID holds a live instruction
//  ex_valid_o     out  1  EX holds a live instruction
//  mem_valid_o    out  1  MEM holds a live instruction
//  wb_valid_o     out  1  WB holds a live instruction
//  refill_o       out  1  controller is in state REFILL
//  stall_cnt_o    out  32 front-end stall cycle count (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async, rst_n=0)
//   - all *_valid_o = 0; state = RUN; gap counter = 0; stall_cnt_o = 0.
//   - Combinational outputs settle to: if_allowin_o = 1, all *_load_o = 0.
//  Allowin chain (combinational, X = stage valid)
//   - wb_allowin  = !wb_valid  | wb_ready_go
//   - mem_allowin = !mem_valid | (mem_ready_go & wb_allowin)
//   - ex_allowin and id_allowin follow the same pattern.
//   - if_allowin_o = (state==RUN) & id_allowin & !excep_flush_i
//  Load enables
//   - id_load_o  = if_valid_i & if_ready_go_i & id_allowin & (state==RUN)
//   - ex_load_o  = id_valid & id_ready_go & ex_allowin
//   - mem_load_o and wb_load_o follow the same pattern.
//   - Every *_load_o is forced to 0 while excep_flush_i = 1.
//  Valid update (posedge clk), for each stage S with upstream U
//   - excep_flush_i=1 : S_valid <= 0 (flush has priority over any load).
//   - else if S_allowin : S_valid <= U_valid & U_ready_go & (S!=ID | state==RUN).
//   - else            : hold.
//   - Stage latency is 1 cycle. Full pipe streaming sustains 1 instruction/cycle
//     with no bubbles.
//  Retire
//   - wb_valid with wb_ready_go retires; wb_valid clears unless a new wb_load occurs.
//  FSM states: RUN, REFILL
//   - RUN: excep_flush_i & FLUSH_GAP>0 → REFILL, counter <= FLUSH_GAP-1.
//     With FLUSH_GAP=0 the state stays RUN.
//   - REFILL: if_allowin_o=0 and id_load_o=0.
//     - excep_flush_i → counter <= FLUSH_GAP-1 (restart the gap).
//     - else counter==0 → RUN.
//     - else counter-1.
//   - Flush at cycle T: all valids are 0 at T+1. if_allowin_o=0 for T..T+FLUSH_GAP.
//     It returns to 1 at T+FLUSH_GAP+1.
//   - Reset mid-REFILL: immediately RUN; counter = 0.
//  Backpressure
//   - A stalled stage holds its valid and drops its own load enable.
//   - It drops all upstream load enables on the same cycle (no instruction loss,
//     no duplication).
// CONFIGURATION
//  PIPE_STALL_CNT_EN
//   - Defined: stall_cnt_o increments each cycle with if_valid_i & !if_allowin_o.
//     It saturates at 32'hFFFF_FFFF and is cleared only by reset.
//   - Not defined: stall_cnt_o tied to 32'd0; no counter flops are synthesized.
// TESTING
//  1. Hold rst_n=0 for 3 cycles.
//     → all valids 0, if_allowin_o=1, all *_load_o=0, refill_o=0.
//     Release rst_n; the pipe stays idle with if_valid_i=0.
//  2. if_valid_i=1, all ready_go=1, first instruction enters ID at T1.
//     → id/ex/mem/wb_valid rise at T1/T2/T3/T4.
//     → all load enables stay 1 every cycle from T4 onward.
//  3. Full pipe, mem_ready_go_i=0 for 3 cycles.
//     → mem_load_o=0, ex_load_o=0, id_load_o=0, if_allowin_o=0 for those 3 cycles.
//     → wb_valid_o drops to 0 one cycle later.
//     → after release all instructions retire in order, none lost.
//  4. Full pipe, FLUSH_GAP=2, excep_flush_i=1 at T.
//     → all valids 0 at T+1, refill_o=1 at T+1..T+2.
//     → if_allowin_o=0 at T..T+2 and 1 at T+3.
//  5. Second excep_flush_i at T+2 during REFILL.
//     → gap restarts, refill_o=1 through T+4, if_allowin_o=1 at T+5.
//     Assert rst_n=0 at T+3 → refill_o=0 immediately.
//  6. PIPE_STALL_CNT_EN defined: if_valid_i=1 with id_ready_go_i=0 for 5 cycles
//     after fill → stall_cnt_o=5.
//     Same stimulus without the macro → stall_cnt_o=0.

Source files
------------

// File: rtl/pipe_stage_if.sv
// Handshake bundle between the five-stage pipe datapath and its controller.
// The master side is the datapath; the slave side is pipe_stage_ctrl.
interface pipe_stage_if;
    logic        if_valid_i;
    logic        if_ready_go_i;
    logic        id_ready_go_i;
    logic        ex_ready_go_i;
    logic        mem_ready_go_i;
    logic        wb_ready_go_i;
    logic        excep_flush_i;

    logic        if_allowin_o;
    logic        id_load_o;
    logic        ex_load_o;
    logic        mem_load_o;
    logic        wb_load_o;
    logic        id_valid_o;
    logic        ex_valid_o;
    logic        mem_valid_o;
    logic        wb_valid_o;
    logic        refill_o;
    logic [31:0] stall_cnt_o;

    modport master (
        output if_valid_i, if_ready_go_i, id_ready_go_i, ex_ready_go_i,
               mem_ready_go_i, wb_ready_go_i, excep_flush_i,
        input  if_allowin_o, id_load_o, ex_load_o, mem_load_o, wb_load_o,
               id_valid_o, ex_valid_o, mem_valid_o, wb_valid_o, refill_o,
               stall_cnt_o
    );

    modport slave (
        input  if_valid_i, if_ready_go_i, id_ready_go_i, ex_ready_go_i,
               mem_ready_go_i, wb_ready_go_i, excep_flush_i,
        output if_allowin_o, id_load_o, ex_load_o, mem_load_o, wb_load_o,
               id_valid_o, ex_valid_o, mem_valid_o, wb_valid_o, refill_o,
               stall_cnt_o
    );
endinterface

// File: rtl/pipe_stage_ctrl.sv
// Valid/allowin/load controller for the IF-ID-EX-MEM-WB pipe with a post-flush refill gap.
// Optional macro PIPE_STALL_CNT_EN adds a saturating front-end stall counter.
module pipe_stage_ctrl #(
    parameter int unsigned FLUSH_GAP = 2
) (
    input logic         clk,
    input logic         rst_n,
    pipe_stage_if.slave bus
);

    typedef enum logic {
        RUN    = 1'b0,
        REFILL = 1'b1
    } state_t;

    localparam bit         GAP_EN     = (FLUSH_GAP > 0);
    localparam logic [3:0] GAP_RELOAD = GAP_EN ? 4'(FLUSH_GAP - 1) : 4'd0;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] gap_cnt;
    logic [3:0] gap_cnt_nxt;

    logic id_valid;
    logic ex_valid;
    logic mem_valid;
    logic wb_valid;

    logic in_run;
    logic flush;
    logic wb_allowin;
    logic mem_allowin;
    logic ex_allowin;
    logic id_allowin;
    logic if_allowin;

    logic id_in;
    logic ex_in;
    logic mem_in;
    logic wb_in;

    assign in_run = (state == RUN);
    assign flush  = bus.excep_flush_i;

    // What each stage would receive from upstream this cycle if it can accept.
    assign id_in  = bus.if_valid_i & bus.if_ready_go_i & in_run;
    assign ex_in  = id_valid  & bus.id_ready_go_i;
    assign mem_in = ex_valid  & bus.ex_ready_go_i;
    assign wb_in  = mem_valid & bus.mem_ready_go_i;

    always_comb begin
        wb_allowin  = !wb_valid  | bus.wb_ready_go_i;
        mem_allowin = !mem_valid | (bus.mem_ready_go_i & wb_allowin);
        ex_allowin  = !ex_valid  | (bus.ex_ready_go_i  & mem_allowin);
        id_allowin  = !id_valid  | (bus.id_ready_go_i  & ex_allowin);
        if_allowin  = in_run & id_allowin & !flush;
    end

    assign bus.if_allowin_o = if_allowin;
    assign bus.id_load_o    = id_in  & id_allowin  & !flush;
    assign bus.ex_load_o    = ex_in  & ex_allowin  & !flush;
    assign bus.mem_load_o   = mem_in & mem_allowin & !flush;
    assign bus.wb_load_o    = wb_in  & wb_allowin  & !flush;

    // Stage valid registers: flush wins over any incoming instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_valid  <= 1'b0;
            ex_valid  <= 1'b0;
            mem_valid <= 1'b0;
            wb_valid  <= 1'b0;
        end else if (flush) begin
            id_valid  <= 1'b0;
            ex_valid  <= 1'b0;
            mem_valid <= 1'b0;
            wb_valid  <= 1'b0;
        end else begin
            if (id_allowin)  id_valid  <= id_in;
            if (ex_allowin)  ex_valid  <= ex_in;
            if (mem_allowin) mem_valid <= mem_in;
            if (wb_allowin)  wb_valid  <= wb_in;
        end
    end

    assign bus.id_valid_o  = id_valid;
    assign bus.ex_valid_o  = ex_valid;
    assign bus.mem_valid_o = mem_valid;
    assign bus.wb_valid_o  = wb_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RUN;
            gap_cnt <= 4'd0;
        end else begin
            state   <= state_nxt;
            gap_cnt <= gap_cnt_nxt;
        end
    end

    // A flush seen while refilling restarts the gap from the top.
    always_comb begin
        state_nxt   = state;
        gap_cnt_nxt = gap_cnt;
        case (state)
            RUN: begin
                if (flush && GAP_EN) begin
                    state_nxt   = REFILL;
                    gap_cnt_nxt = GAP_RELOAD;
                end
            end
            REFILL: begin
                if (flush) begin
                    gap_cnt_nxt = GAP_RELOAD;
                end else if (gap_cnt == 4'd0) begin
                    state_nxt = RUN;
                end else begin
                    gap_cnt_nxt = gap_cnt - 4'd1;
                end
            end
            default: begin
                state_nxt   = RUN;
                gap_cnt_nxt = 4'd0;
            end
        endcase
    end

    assign bus.refill_o = (state == REFILL);

`ifdef PIPE_STALL_CNT_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= 32'd0;
        end else if (bus.if_valid_i && !if_allowin && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign bus.stall_cnt_o = stall_cnt;
`else
    assign bus.stall_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Bench for pipe_stage_ctrl: directed vector table, hand-written flush/reset/stall
// sequences, then random traffic against an occupancy-and-flush-time reference model.
module tb_pipe_stage_ctrl;

    localparam int unsigned GAP = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pipe_stage_if bus ();

    pipe_stage_ctrl #(.FLUSH_GAP(GAP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic       rst_n;
        logic       if_valid;
        logic [4:0] rg;       // if, id, ex, mem, wb ready_go
        logic       flush;
        logic       allowin;
        logic [3:0] load;     // id, ex, mem, wb
        logic [3:0] valid;    // id, ex, mem, wb
        logic       refill;
    } vec_t;

    typedef struct packed {
        logic        allowin;
        logic [3:0]  load;
        logic [3:0]  valid;
        logic        refill;
        logic [31:0] stall;
    } exp_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [4:0] rg, input logic fl);
        bus.if_valid_i     = iv;
        bus.if_ready_go_i  = rg[4];
        bus.id_ready_go_i  = rg[3];
        bus.ex_ready_go_i  = rg[2];
        bus.mem_ready_go_i = rg[1];
        bus.wb_ready_go_i  = rg[0];
        bus.excep_flush_i  = fl;
    endtask

    function automatic logic [3:0] loads();
        return {bus.id_load_o, bus.ex_load_o, bus.mem_load_o, bus.wb_load_o};
    endfunction

    function automatic logic [3:0] valids();
        return {bus.id_valid_o, bus.ex_valid_o, bus.mem_valid_o, bus.wb_valid_o};
    endfunction

    // Reference model: stage occupancy plus the time of the most recent flush.
    bit          m_occ [4];
    int          m_cyc;
    int          m_last_flush;
    logic [31:0] m_stall;

    task automatic model_reset();
        for (int s = 0; s < 4; s++) m_occ[s] = 1'b0;
        m_cyc        = 0;
        m_last_flush = -100;
        m_stall      = 32'd0;
    endtask

    task automatic model_cycle(output exp_t e);
        bit acc [4];
        bit inc [4];
        bit rdy [4];
        bit run;
        bit fl;
        bit nxt;
        rdy[0] = bus.id_ready_go_i;
        rdy[1] = bus.ex_ready_go_i;
        rdy[2] = bus.mem_ready_go_i;
        rdy[3] = bus.wb_ready_go_i;
        fl     = bus.excep_flush_i;
        e.refill = (GAP > 0) && (m_cyc > m_last_flush) && (m_cyc <= m_last_flush + int'(GAP));
        run = !e.refill;
        nxt = 1'b1;
        for (int s = 3; s >= 0; s--) begin
            acc[s] = !m_occ[s] || (rdy[s] && nxt);
            nxt    = acc[s];
        end
        inc[0] = bus.if_valid_i && bus.if_ready_go_i && run;
        for (int s = 1; s < 4; s++) inc[s] = m_occ[s-1] && rdy[s-1];
        e.allowin = run && acc[0] && !fl;
        for (int s = 0; s < 4; s++) begin
            e.load[3-s]  = inc[s] && acc[s] && !fl;
            e.valid[3-s] = m_occ[s];
        end
        e.stall = m_stall;
        if (bus.if_valid_i && !e.allowin && m_stall != 32'hFFFF_FFFF) m_stall++;
        if (fl) begin
            m_last_flush = m_cyc;
            for (int s = 0; s < 4; s++) m_occ[s] = 1'b0;
        end else begin
            for (int s = 0; s < 4; s++) if (acc[s]) m_occ[s] = inc[s];
        end
        m_cyc++;
    endtask

    vec_t vecs [22];

    function automatic vec_t mkv(logic r, logic iv, logic [4:0] rg, logic fl,
                                 logic al, logic [3:0] ld, logic [3:0] vl, logic rf);
        vec_t v;
        v.rst_n = r; v.if_valid = iv; v.rg = rg; v.flush = fl;
        v.allowin = al; v.load = ld; v.valid = vl; v.refill = rf;
        return v;
    endfunction

    initial begin
        exp_t        e;
        logic [31:0] stall_exp;
        logic [4:0]  rg;

        // Reset, fill, MEM backpressure for 3 cycles, flush then a second flush in REFILL.
        vecs[0]  = mkv(0, 0, 5'b11111, 0, 1, 4'b0000, 4'b0000, 0);
        vecs[1]  = mkv(0, 0, 5'b11111, 0, 1, 4'b0000, 4'b0000, 0);
        vecs[2]  = mkv(0, 0, 5'b11111, 0, 1, 4'b0000, 4'b0000, 0);
        vecs[3]  = mkv(1, 0, 5'b11111, 0, 1, 4'b0000, 4'b0000, 0);
        vecs[4]  = mkv(1, 1, 5'b11111, 0, 1, 4'b1000, 4'b0000, 0);
        vecs[5]  = mkv(1, 1, 5'b11111, 0, 1, 4'b1100, 4'b1000, 0);
        vecs[6]  = mkv(1, 1, 5'b11111, 0, 1, 4'b1110, 4'b1100, 0);
        vecs[7]  = mkv(1, 1, 5'b11111, 0, 1, 4'b1111, 4'b1110, 0);
        vecs[8]  = mkv(1, 1, 5'b11111, 0, 1, 4'b1111, 4'b1111, 0);
        vecs[9]  = mkv(1, 1, 5'b11111, 0, 1, 4'b1111, 4'b1111, 0);
        vecs[10] = mkv(1, 1, 5'b11101, 0, 0, 4'b0000, 4'b1111, 0);
        vecs[11] = mkv(1, 1, 5'b11101, 0, 0, 4'b0000, 4'b1110, 0);
        vecs[12] = mkv(1, 1, 5'b11101, 0, 0, 4'b0000, 4'b1110, 0);
        vecs[13] = mkv(1, 1, 5'b11111, 0, 1, 4'b1111, 4'b1110, 0);
        vecs[14] = mkv(1, 1, 5'b11111, 0, 1, 4'b1111, 4'b1111, 0);
        vecs[15] = mkv(1, 1, 5'b11111, 1, 0, 4'b0000, 4'b1111, 0);
        vecs[16] = mkv(1, 1, 5'b11111, 0, 0, 4'b0000, 4'b0000, 1);
        vecs[17] = mkv(1, 1, 5'b11111, 1, 0, 4'b0000, 4'b0000, 1);
        vecs[18] = mkv(1, 1, 5'b11111, 0, 0, 4'b0000, 4'b0000, 1);
        vecs[19] = mkv(1, 1, 5'b11111, 0, 0, 4'b0000, 4'b0000, 1);
        vecs[20] = mkv(1, 1, 5'b11111, 0, 1, 4'b1000, 4'b0000, 0);
        vecs[21] = mkv(1, 1, 5'b11111, 0, 1, 4'b1100, 4'b1000, 0);

        rst_n = 1'b1;
        drive(0, 5'b11111, 0);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 22; i++) begin
            rst_n = vecs[i].rst_n;
            drive(vecs[i].if_valid, vecs[i].rg, vecs[i].flush);
            @(negedge clk);
            check($sformatf("row%0d allowin", i), 32'(bus.if_allowin_o), 32'(vecs[i].allowin));
            check($sformatf("row%0d load", i),    32'(loads()),          32'(vecs[i].load));
            check($sformatf("row%0d valid", i),   32'(valids()),         32'(vecs[i].valid));
            check($sformatf("row%0d refill", i),  32'(bus.refill_o),     32'(vecs[i].refill));
            @(posedge clk); #1;
        end

        // Asynchronous reset in the middle of a refill gap.
        drive(1, 5'b11111, 1);
        @(negedge clk);
        check("flush allowin", 32'(bus.if_allowin_o), 32'd0);
        check("flush load",    32'(loads()),          32'd0);
        @(posedge clk); #1;
        drive(0, 5'b11111, 0);
        @(negedge clk);
        check("gap refill", 32'(bus.refill_o), 32'd1);
        check("gap valid",  32'(valids()),     32'd0);
        rst_n = 1'b0;
        #1;
        check("rst refill",  32'(bus.refill_o),     32'd0);
        check("rst allowin", 32'(bus.if_allowin_o), 32'd1);
        check("rst load",    32'(loads()),          32'd0);
        check("rst stall",   bus.stall_cnt_o,       32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Fill, then ID interlock for 5 cycles with IF still presenting work.
        drive(1, 5'b11111, 0);
        repeat (4) begin
            @(posedge clk); #1;
        end
        drive(1, 5'b10111, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("interlock%0d allowin", i), 32'(bus.if_allowin_o), 32'd0);
            check($sformatf("interlock%0d id_load", i), 32'(bus.id_load_o),    32'd0);
            @(posedge clk); #1;
        end
        drive(0, 5'b11111, 0);
        @(negedge clk);
`ifdef PIPE_STALL_CNT_EN
        stall_exp = 32'd5;
`else
        stall_exp = 32'd0;
`endif
        check("stall count", bus.stall_cnt_o, stall_exp);
        @(posedge clk); #1;

        // Random traffic against the reference model.
        rst_n = 1'b0;
        drive(0, 5'b11111, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < 5; b++) rg[b] = ($urandom_range(3) != 0);
            drive($urandom_range(3) != 0, rg, $urandom_range(15) == 0);
            @(negedge clk);
            model_cycle(e);
`ifndef PIPE_STALL_CNT_EN
            e.stall = 32'd0;
`endif
            check("rand allowin", 32'(bus.if_allowin_o), 32'(e.allowin));
            check("rand load",    32'(loads()),          32'(e.load));
            check("rand valid",   32'(valids()),         32'(e.valid));
            check("rand refill",  32'(bus.refill_o),     32'(e.refill));
            check("rand stall",   bus.stall_cnt_o,       e.stall);
            @(posedge clk); #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
